sub_bytes_engine: RTL and testbench



---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox_lane.sv | 12 +
 rtl/sub_bytes_engine.sv | 114 +++++++++++
 tb/tb_sub_bytes_engine.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box tables, lookup helpers and the
// SubBytes engine state type.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sbe_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational S-box; inv_i picks the inverse table.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic       inv_i,
    output logic [7:0] byte_o
);

    assign byte_o = inv_i ? inv_sbox(byte_i) : sbox(byte_i);

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes: substitutes LANES bytes per cycle of a WIDTH-bit
// block, forward or inverse, behind valid/ready handshakes on both sides.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             inv_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the sender holds valid and data stable until that edge.
    localparam int NBYTES = WIDTH / 8;
    localparam int BEATS  = NBYTES / LANES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((WIDTH % 8) != 0) begin : g_bad_width
        $error("sub_bytes_engine: WIDTH must be a multiple of 8");
    end
    if ((NBYTES % LANES) != 0) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must divide WIDTH/8");
    end

    sbe_state_t       state;
    sbe_state_t       state_n;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_sub;
    logic [CW-1:0]    cnt;
    logic             mode;
    logic             accept;
    logic             last_beat;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    assign accept    = valid_i && ready_o;
    assign last_beat = (cnt == LAST_BEAT);
    assign data_o    = work;

    // Byte group cnt of the working register feeds the lanes, LSB group first.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work[(int'(cnt) * LANES + l) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lane u_lane (
            .byte_i (lane_in[g]),
            .inv_i  (mode),
            .byte_o (lane_out[g])
        );
    end

    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            work_sub[(int'(cnt) * LANES + l) * 8 +: 8] = lane_out[l];
        end
    end

    // ready_i -> ready_o in DONE is the only combinational path through the block.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = 1'b1;
            DONE: begin
                ready_o = ready_i;
                valid_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (last_beat) state_n = DONE;
            DONE: if (ready_i) state_n = valid_i ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                work <= data_i;
                mode <= inv_i;
                cnt  <= '0;
            end else if (state == RUN) begin
                work <= work_sub;
                cnt  <= last_beat ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine with LANES=4, 16 and 1 instances.
module tb_sub_bytes_engine;

    logic         clk;
    logic         rst;
    logic [2:0]   vin;
    logic [2:0]   rdy_out;
    logic [127:0] din [3];
    logic [2:0]   inv;
    logic [2:0]   vout;
    logic [2:0]   rdy_in;
    logic [127:0] dout [3];

    int checks = 0;
    int errors = 0;

    sub_bytes_engine #(.WIDTH(128), .LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .valid_i(vin[0]), .ready_o(rdy_out[0]), .data_i(din[0]),
        .inv_i(inv[0]), .valid_o(vout[0]), .ready_i(rdy_in[0]), .data_o(dout[0]));
    sub_bytes_engine #(.WIDTH(128), .LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .valid_i(vin[1]), .ready_o(rdy_out[1]), .data_i(din[1]),
        .inv_i(inv[1]), .valid_o(vout[1]), .ready_i(rdy_in[1]), .data_o(dout[1]));
    sub_bytes_engine #(.WIDTH(128), .LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .valid_i(vin[2]), .ready_o(rdy_out[2]), .data_i(din[2]),
        .inv_i(inv[2]), .valid_o(vout[2]), .ready_i(rdy_in[2]), .data_o(dout[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one block, then waits (bounded) for valid_o and checks latency and data.
    // With wiggle set, inv_i/data_i/valid_i are disturbed during the first RUN cycle.
    task automatic run_block(input int idx, input logic [127:0] d, input logic md,
                             input logic [127:0] exp, input int lat, input logic wiggle,
                             input string tag);
        int n;
        vin[idx] = 1'b1;
        din[idx] = d;
        inv[idx] = md;
        #1;
        check({tag, "_ready_at_offer"}, 128'(rdy_out[idx]), 128'd1);
        tick();
        vin[idx] = 1'b0;
        n = 0;
        while (vout[idx] !== 1'b1 && n < 64) begin
            if (wiggle) begin
                if (n == 0) begin
                    vin[idx] = 1'b1;
                    din[idx] = ~d;
                    inv[idx] = ~md;
                end else begin
                    vin[idx] = 1'b0;
                end
            end
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_valid"}, 128'(vout[idx]), 128'd1);
        check({tag, "_data"}, dout[idx], exp);
    endtask

    localparam logic [127:0] V_A_IN  = 128'hea125a0004455000_0000000000000000;
    localparam logic [127:0] V_A_OUT = 128'h87c9be63f26e5363_6363636363636363;
    localparam logic [127:0] V_B_IN  = 128'hffeeddccbbaa9988_7766554433221100;
    localparam logic [127:0] V_B_OUT = 128'h1628c14beaaceec4_f533fc1bc3938263;
    localparam logic [127:0] V_63    = {16{8'h63}};

    initial begin
        rst    = 1'b1;
        vin    = '0;
        inv    = '0;
        rdy_in = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_valid_o", 128'(vout[i]), 128'd0);
            check("reset_ready_o", 128'(rdy_out[i]), 128'd1);
            check("reset_data_o", dout[i], 128'd0);
        end
        rst = 1'b0;
        tick();

        // LANES=4 forward, downstream stalled
        run_block(0, V_A_IN, 1'b0, V_A_OUT, 4, 1'b0, "l4_fwd");
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid_o", 128'(vout[0]), 128'd1);
            check("bp_ready_o", 128'(rdy_out[0]), 128'd0);
            check("bp_data_o", dout[0], V_A_OUT);
        end

        // Release with a new block offered in the same cycle
        rdy_in[0] = 1'b1;
        run_block(0, V_B_IN, 1'b0, V_B_OUT, 4, 1'b0, "l4_b2b");
        vin[0] = 1'b0;
        tick();
        check("l4_idle_ready", 128'(rdy_out[0]), 128'd1);
        check("l4_idle_valid", 128'(vout[0]), 128'd0);

        // LANES=16 forward: single beat
        rdy_in[1] = 1'b1;
        run_block(1, V_B_IN, 1'b0, V_B_OUT, 1, 1'b0, "l16_fwd");

        // LANES=1 inverse, two blocks back to back
        rdy_in[2] = 1'b1;
        run_block(2, V_B_OUT, 1'b1, V_B_IN, 16, 1'b0, "l1_inv");
        run_block(2, V_63, 1'b1, 128'd0, 16, 1'b0, "l1_inv63");
        tick();
        check("l1_idle_valid", 128'(vout[2]), 128'd0);

        // Mode latched at accept; inputs disturbed during RUN have no effect
        run_block(0, V_A_IN, 1'b0, V_A_OUT, 4, 1'b1, "mode_fwd");
        run_block(0, V_63, 1'b1, 128'd0, 4, 1'b1, "mode_inv");
        vin[0] = 1'b0;
        tick();

        // Reset two beats into a block
        vin[0] = 1'b1;
        din[0] = V_B_IN;
        inv[0] = 1'b0;
        tick();
        vin[0] = 1'b0;
        tick();
        tick();
        check("mid_run_ready", 128'(rdy_out[0]), 128'd0);
        rst = 1'b1;
        #1;
        check("rst_valid_o", 128'(vout[0]), 128'd0);
        check("rst_data_o", dout[0], 128'd0);
        check("rst_ready_o", 128'(rdy_out[0]), 128'd1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 128'(rdy_out[0]), 128'd1);
        check("post_rst_valid", 128'(vout[0]), 128'd0);
        run_block(0, V_A_IN, 1'b0, V_A_OUT, 4, 1'b0, "post_rst");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
